ldm_stm_seq: RTL and testbench
==============================

// Module: ldm_stm_seq
// PURPOSE
//  Multicycle sequencer for ARM LDM/STM block transfers. Walks a 16-bit register list and drives
//  the register-file ports (read port 2, write port 3) and a single-outstanding bus-request
//  handshake toward the AHB master. Performs optional base write-back.
//  Sits beside the main controller FSM, which hands over on start and regains control on done.
// PARAMETERS
//  XLEN        32   data/address width
//  BUS_TIMEOUT 0    max wait cycles per beat before abort; 0 = no timeout
// PORTS
//  clk        in   1     clock, all state on rising edge
//  reset      in   1     asynchronous, active-high reset
//  start      in   1     launch transfer; sampled only in IDLE
//  is_load    in   1     1 = LDM, 0 = STM
//  pre, up    in   1,1   P/U bits: IA(0,1) IB(1,1) DA(0,0) DB(1,0)
//  wback      in   1     W bit: write updated base to rn
//  rn         in   4     base register index
//  base       in   XLEN  value of rn at start
//  reglist    in   16    register list, bit i = Ri
//  rf_ra      out  4     register-file read address (STM data)
//  rf_rd      in   XLEN  register-file read data
//  rf_we      out  1     register-file write enable
//  rf_wa      out  4     register-file write address
//  rf_wd      out  XLEN  register-file write data
//  pc_we      out  1     load into R15: pc_wd valid this cycle
//  pc_wd      out  XLEN  loaded PC value
//  bus_req    out  1     transfer request, held until bus_ready
//  bus_write  out  1     1 = store beat
//  bus_addr   out  XLEN  word address, bits[1:0] = 0
//  bus_wdata  out  XLEN  store data (= rf_rd)
//  bus_ready  in   1     beat completes on this clock edge
//  bus_rdata  in   XLEN  load data, valid with bus_ready
//  busy       out  1     high outside IDLE
//  done       out  1     one-cycle completion pulse
//  err        out  1     one-cycle pulse with done on timeout abort
// BEHAVIOUR
//  Reset: FSM in IDLE. All outputs 0; latched list, address and counters cleared.
//  Reset mid-operation: abandons the transfer immediately, with no write-back and no done.
//  States: IDLE -> XFER -> (WB) -> IDLE. done/err are registered, asserted the cycle after the last action.
//  IDLE: on start, latch is_load/wback/rn/reglist and n = popcount(reglist).
//   Start address: IA = base; IB = base+4; DA = base-4n+4; DB = base-4n (mod 2^XLEN).
//   Write-back value: base + 4n if up, else base - 4n.
//   start while busy is ignored.
//  XFER: current register = lowest set bit of the remaining list; addresses ascend by 4 from the start address.
//   bus_req = 1 while in XFER; bus_addr/bus_write/bus_wdata are stable until bus_ready.
//   rf_ra = current index.
//   On bus_ready: clear the bit and advance the address by 4.
//    If load with index < 15: rf_we = 1, rf_wa = idx, rf_wd = bus_rdata, all in the same cycle.
//    If load with index 15: pc_we = 1, pc_wd = bus_rdata; rf_we stays 0.
//   Last bit consumed -> WB if wback, else IDLE with done.
//  WB: one cycle with rf_we = 1, rf_wa = rn, rf_wd = write-back value, then done.
//   WB is skipped (straight to done) when is_load and reglist[rn] = 1; the loaded value wins.
//   rn = 15 with wback: WB is skipped.
//  Empty reglist: no beats, no WB; done pulses the cycle after start.
//  Timeout (BUS_TIMEOUT > 0): a wait counter resets each beat. Reaching BUS_TIMEOUT without bus_ready
//   drops bus_req, pulses done + err, and skips WB. Registers already loaded stay written.
//  rf_we and pc_we are never asserted together; rf_we is 0 in IDLE.
// STRUCTURE
//  ldm_pkg: typedef enum {IDLE, XFER, WB} ldm_state_t; addressing-mode enum {IA, IB, DA, DB};
//   localparam WORD_BYTES = 4.
//  Sub-module reglist_scan (combinational): 16-bit list -> lowest set index, valid, popcount.
// TESTING
//  STMIA rn=R13 base=0x100 list=0x000E, bus_ready each cycle
//   -> addrs 0x100/104/108, rf_ra 1/2/3, done after 3 beats, no rf_we.
//  LDMDB base=0x200 list=0x8003 wback, ready after 2 waits each
//   -> addrs 0x1F4/1F8/1FC; R0, R1 written; pc_we on 3rd beat; WB rn=0x1F4.
//  LDMIA rn=R2 list=0x0004 wback, rdata 0xDEAD
//   -> R2 = 0xDEAD, no WB cycle.
//  reglist = 0 -> done one cycle after start, bus_req never high.
//  BUS_TIMEOUT=4, bus_ready held 0 -> bus_req for 4 cycles, then done+err, no WB.
//  Assert reset during 2nd beat of STMIB -> bus_req/busy low immediately, no done;
//   next start runs normally.

Source files
------------

// File: rtl/ldm_pkg.sv
// rtl/ldm_pkg.sv - shared types and constants for the LDM/STM block-transfer sequencer
package ldm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2
  } ldm_state_t;

  // Encoded as {pre, up} so the P/U bits map straight onto the mode.
  typedef enum logic [1:0] {
    DA = 2'b00,
    IA = 2'b01,
    DB = 2'b10,
    IB = 2'b11
  } addr_mode_t;

  localparam int WORD_BYTES = 4;

  function automatic addr_mode_t addr_mode(input logic pre, input logic up);
    return addr_mode_t'({pre, up});
  endfunction

endpackage

// File: rtl/ldm_stm_seq_reglist_scan.sv
// rtl/ldm_stm_seq_reglist_scan.sv - lowest set index, non-empty flag and popcount of a register list
module reglist_scan (
  input  logic [15:0] list,
  output logic [3:0]  idx,
  output logic        valid,
  output logic [4:0]  count
);

  // Priority scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    idx   = 4'd0;
    count = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (list[i]) begin
        idx = 4'(i);
      end
      count = count + 5'(list[i]);
    end
    valid = |list;
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// rtl/ldm_stm_seq.sv - multicycle LDM/STM sequencer driving register file and bus handshake
module ldm_stm_seq
  import ldm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BUS_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_load,
  input  logic            pre,
  input  logic            up,
  input  logic            wback,
  input  logic [3:0]      rn,
  input  logic [XLEN-1:0] base,
  input  logic [15:0]     reglist,
  output logic [3:0]      rf_ra,
  input  logic [XLEN-1:0] rf_rd,
  output logic            rf_we,
  output logic [3:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            pc_we,
  output logic [XLEN-1:0] pc_wd,
  output logic            bus_req,
  output logic            bus_write,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ready,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam bit          TIMEOUT_EN = (BUS_TIMEOUT > 0);
  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT_EN ? BUS_TIMEOUT - 1 : 0);
  localparam logic [XLEN-1:0] STEP   = XLEN'(WORD_BYTES);

  ldm_state_t      state_q, state_d;
  logic            is_load_q, is_load_d;
  logic            do_wb_q, do_wb_d;
  logic [3:0]      rn_q, rn_d;
  logic [15:0]     list_q, list_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wbval_q, wbval_d;
  logic [15:0]     wait_q, wait_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // One scanner serves both phases: the incoming list in IDLE, the remaining list otherwise.
  logic [15:0]     scan_list;
  logic [3:0]      cur_idx;
  logic            scan_valid;
  logic [4:0]      scan_count;
  logic [XLEN-1:0] span;

  assign scan_list = (state_q == IDLE) ? reglist : list_q;
  assign span      = XLEN'(scan_count) * STEP;

  reglist_scan u_scan (
    .list  (scan_list),
    .idx   (cur_idx),
    .valid (scan_valid),
    .count (scan_count)
  );

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

  // State register; an asserted reset drops any transfer in flight without write-back or done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      is_load_q <= 1'b0;
      do_wb_q   <= 1'b0;
      rn_q      <= 4'd0;
      list_q    <= 16'd0;
      addr_q    <= '0;
      wbval_q   <= '0;
      wait_q    <= 16'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      do_wb_q   <= do_wb_d;
      rn_q      <= rn_d;
      list_q    <= list_d;
      addr_q    <= addr_d;
      wbval_q   <= wbval_d;
      wait_q    <= wait_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state and output decode: latch the job in IDLE, one beat per bus_ready in XFER, base update in WB.
  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    do_wb_d   = do_wb_q;
    rn_d      = rn_q;
    list_d    = list_q;
    addr_d    = addr_q;
    wbval_d   = wbval_q;
    wait_d    = wait_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    rf_ra     = 4'd0;
    rf_we     = 1'b0;
    rf_wa     = 4'd0;
    rf_wd     = '0;
    pc_we     = 1'b0;
    pc_wd     = '0;
    bus_req   = 1'b0;
    bus_write = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_load_d = is_load;
          rn_d      = rn;
          list_d    = reglist;
          wait_d    = 16'd0;
          wbval_d   = up ? (base + span) : (base - span);
          // A loaded base register keeps its loaded value; R15 is never a write-back target.
          do_wb_d   = wback && (rn != 4'd15) && !(is_load && reglist[rn]);
          unique case (addr_mode(pre, up))
            IA:      addr_d = base;
            IB:      addr_d = base + STEP;
            DA:      addr_d = base - span + STEP;
            default: addr_d = base - span;
          endcase
          if (scan_valid) begin
            state_d = XFER;
          end else begin
            done_d  = 1'b1;
          end
        end
      end

      XFER: begin
        bus_req   = 1'b1;
        bus_write = !is_load_q;
        bus_addr  = addr_q;
        rf_ra     = cur_idx;
        bus_wdata = is_load_q ? '0 : rf_rd;
        if (bus_ready) begin
          list_d = list_q & ~(16'd1 << cur_idx);
          addr_d = addr_q + STEP;
          wait_d = 16'd0;
          if (is_load_q) begin
            if (cur_idx == 4'd15) begin
              pc_we = 1'b1;
              pc_wd = bus_rdata;
            end else begin
              rf_we = 1'b1;
              rf_wa = cur_idx;
              rf_wd = bus_rdata;
            end
          end
          if (scan_count == 5'd1) begin
            if (do_wb_q) begin
              state_d = WB;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
          state_d = IDLE;
          list_d  = 16'd0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (TIMEOUT_EN) begin
          wait_d = wait_q + 16'd1;
        end
      end

      WB: begin
        rf_we   = 1'b1;
        rf_wa   = rn_q;
        rf_wd   = wbval_q;
        state_d = IDLE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// tb/tb_ldm_stm_seq.sv - randomized scoreboard bench for the LDM/STM sequencer
module tb_ldm_stm_seq;

  localparam int XLEN = 32;
  localparam int TMO  = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0, is_load = 1'b0, pre = 1'b0, up = 1'b0, wback = 1'b0;
  logic [3:0]      rn = 4'd0;
  logic [XLEN-1:0] base = '0;
  logic [15:0]     reglist = 16'd0;
  logic [3:0]      rf_ra, rf_wa;
  logic [XLEN-1:0] rf_rd, rf_wd, pc_wd, bus_addr, bus_wdata;
  logic            rf_we, pc_we, bus_req, bus_write, busy, done, err;
  logic            bus_ready = 1'b0;
  logic [XLEN-1:0] bus_rdata = '0;

  ldm_stm_seq #(.XLEN(XLEN), .BUS_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .pre(pre), .up(up),
    .wback(wback), .rn(rn), .base(base), .reglist(reglist), .rf_ra(rf_ra), .rf_rd(rf_rd),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .pc_we(pc_we), .pc_wd(pc_wd),
    .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0] regs [16];
  assign rf_rd = regs[rf_ra];

  logic [XLEN-1:0] mem_ovr [logic [XLEN-1:0]];

  function automatic logic [XLEN-1:0] mem_val(input logic [XLEN-1:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  typedef struct { logic [XLEN-1:0] addr; logic wr; logic [XLEN-1:0] wdata; logic [3:0] idx; } beat_t;
  typedef struct { logic [3:0] wa; logic [XLEN-1:0] wd; } rfw_t;
  typedef struct { logic err; int cyc; } done_t;

  beat_t           beat_q [$];
  rfw_t            rfw_q  [$];
  logic [XLEN-1:0] pc_q   [$];
  done_t           done_q [$];

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int req_cycles = 0;
  int w_cfg = 0, stall_cfg = -1, beat_i = 0, wcnt = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Bus slave: each beat gets w_cfg wait cycles, except beat stall_cfg which never completes.
  always @(posedge clk) begin
    #1;
    if (reset || !busy) begin
      bus_ready = 1'b0;
      beat_i    = 0;
      wcnt      = 0;
    end else if (bus_req) begin
      if (beat_i != stall_cfg && wcnt == w_cfg) begin
        bus_ready = 1'b1;
        bus_rdata = mem_val(bus_addr);
        beat_i++;
        wcnt = 0;
      end else begin
        bus_ready = 1'b0;
        bus_rdata = $urandom;
        wcnt++;
      end
    end else begin
      bus_ready = 1'b0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a beat, a register write, a PC write or done.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_req) req_cycles++;
      if (rf_we && pc_we) flag("rf_pc_both");
      if (err && !done) flag("err_without_done");
      if (bus_req && bus_ready) begin
        if (beat_q.size() == 0) flag("extra_beat");
        else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("bus_addr", bus_addr, b.addr);
          chk("bus_write", 32'(bus_write), 32'(b.wr));
          chk("rf_ra", 32'(rf_ra), 32'(b.idx));
          if (b.wr) chk("bus_wdata", bus_wdata, b.wdata);
        end
      end
      if (rf_we) begin
        if (rfw_q.size() == 0) flag("extra_rf_we");
        else begin
          rfw_t r;
          r = rfw_q.pop_front();
          chk("rf_wa", 32'(rf_wa), 32'(r.wa));
          chk("rf_wd", rf_wd, r.wd);
        end
      end
      if (pc_we) begin
        if (pc_q.size() == 0) flag("extra_pc_we");
        else chk("pc_wd", pc_wd, pc_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) flag("extra_done");
        else begin
          done_t d;
          d = done_q.pop_front();
          chk("done_err", 32'(err), 32'(d.err));
          chk("done_cycle", 32'(cyc), 32'(d.cyc));
        end
      end
    end
  end

  // Reference model: ascending addresses from the mode's lowest word, registers in ascending order.
  task automatic predict(input logic ld, input logic p, input logic u, input logic wb,
                         input logic [3:0] r, input logic [XLEN-1:0] b, input logic [15:0] lst,
                         input int w, input int stall, input int s_cyc);
    int n, k, lat;
    logic [XLEN-1:0] lo, a;
    logic aborted, do_wb;
    n = $countones(lst);
    case ({p, u})
      2'b01:   lo = b;
      2'b11:   lo = b + 4;
      2'b00:   lo = b - 4 * n + 4;
      default: lo = b - 4 * n;
    endcase
    aborted = (stall >= 0) && (stall < n);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst[i] && !(aborted && k >= stall)) begin
        a = lo + 4 * k;
        beat_q.push_back('{addr: a, wr: !ld, wdata: regs[i], idx: 4'(i)});
        if (ld && i == 15) pc_q.push_back(mem_val(a));
        else if (ld) rfw_q.push_back('{wa: 4'(i), wd: mem_val(a)});
        k++;
      end
    end
    do_wb = wb && (r != 4'd15) && !(ld && lst[r]) && !aborted && (n > 0);
    if (do_wb) rfw_q.push_back('{wa: r, wd: u ? b + 4 * n : b - 4 * n});
    lat = aborted ? stall * (w + 1) + TMO : n * (w + 1) + (do_wb ? 1 : 0);
    done_q.push_back('{err: aborted, cyc: s_cyc + lat});
  endtask

  task automatic scramble_inputs();
    is_load = 1'($urandom); pre = 1'($urandom); up = 1'($urandom); wback = 1'($urandom);
    rn = 4'($urandom); base = $urandom; reglist = 16'($urandom);
  endtask

  task automatic flush();
    beat_q.delete(); rfw_q.delete(); pc_q.delete(); done_q.delete();
  endtask

  task automatic run_xfer(input logic ld, input logic p, input logic u, input logic wb,
                          input logic [3:0] r, input logic [XLEN-1:0] b, input logic [15:0] lst,
                          input int w, input int stall, input bit junk);
    int t;
    @(posedge clk); #1;
    is_load = ld; pre = p; up = u; wback = wb; rn = r; base = b; reglist = lst;
    w_cfg = w; stall_cfg = stall; req_cycles = 0;
    start = 1'b1;
    predict(ld, p, u, wb, r, b, lst, w, stall, cyc + 1);
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    if (junk) begin
      @(posedge clk); #1;
      if (busy) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    t = 0;
    while (done_q.size() > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (done_q.size() > 0) begin
      flag("done_timeout");
      flush();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [XLEN-1:0] rb;
    logic [15:0] rl;
    int w, st, n;

    for (int i = 0; i < 16; i++) regs[i] = $urandom;

    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_pc_we", 32'(pc_we), 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_rf_wd", rf_wd, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // STMIA R13, {R1-R3}, single-cycle beats
    run_xfer(1'b0, 1'b0, 1'b1, 1'b0, 4'd13, 32'h100, 16'h000E, 0, -1, 1'b0);
    // LDMDB R4!, {R0,R1,PC}, two waits per beat
    run_xfer(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 32'h200, 16'h8003, 2, -1, 1'b0);
    // LDMIA R2!, {R2}: loaded value wins over write-back
    mem_ovr[32'h300] = 32'h0000_DEAD;
    run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h300, 16'h0004, 0, -1, 1'b0);
    // empty list
    run_xfer(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 32'h400, 16'h0000, 0, -1, 1'b0);
    chk("empty_bus_req", 32'(req_cycles), 0);
    // timeout on first beat
    run_xfer(1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 32'h500, 16'h0003, 0, 0, 1'b0);
    chk("timeout_req_cycles", 32'(req_cycles), TMO);
    // rn = R15 with write-back: skipped
    run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd15, 32'h600, 16'h0030, 1, -1, 1'b0);
    // DA with wrap below zero
    run_xfer(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h4, 16'h00C2, 0, -1, 1'b0);

    // reset during the second beat of STMIB
    @(posedge clk); #1;
    is_load = 1'b0; pre = 1'b1; up = 1'b1; wback = 1'b1; rn = 4'd3; base = 32'h700;
    reglist = 16'h00F0; w_cfg = 0; stall_cfg = -1;
    start = 1'b1;
    predict(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 32'h700, 16'h00F0, 0, -1, cyc + 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    flush();
    #1;
    chk("midrst_bus_req", 32'(bus_req), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_rf_we", 32'(rf_we), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    run_xfer(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 32'h700, 16'h00F0, 0, -1, 1'b0);

    // randomized transfers
    for (int it = 0; it < 60; it++) begin
      rb = $urandom;
      rb[1:0] = 2'b00;
      rl = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rl = 16'd1 << $urandom_range(0, 15);
      if ($urandom_range(0, 15) == 0) rl = 16'd0;
      n = $countones(rl);
      w = $urandom_range(0, 2);
      st = (n > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
      run_xfer(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
               rb, rl, w, st, 1'($urandom));
    end

    chk("left_beats", 32'(beat_q.size()), 0);
    chk("left_rf_writes", 32'(rfw_q.size()), 0);
    chk("left_pc_writes", 32'(pc_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
